// File: rtl/rv32_pkg.sv
// Shared RV32I fetch-stage definitions: NOP encoding, reset vector, fetch FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package rv32_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Sequential PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: captures (pc, instr) with a valid bit; resets to NOP.
// Latency: 1 cycle from load_i to outputs. Ports: load_i/bubble_i controls, pc_i/instr_i in, valid/pc/pc+4/instr out.
// Backpressure: holds contents when neither load_i nor bubble_i is set; load_i wins over bubble_i.
module if_id_reg
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // A bubble kills the instruction but keeps the PC fields, so the link
  // value downstream stays that of the last real instruction.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (bubble_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_next(pc_q);
  assign instr_o    = instr_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, addresses the combinational imem, fills IF/ID.
// Latency: instruction at A appears on IF/ID one edge after imem_addr = A; redirect costs one bubble.
// Backpressure: stall_i holds PC and IF/ID; redirect overrides stall; misaligned redirect -> sticky FAULT.
// Ports: clk/rst_n; imem_addr/imem_instr; stall_i, flush_i, redirect_valid_i/redirect_pc_i;
//        if_id_{valid,pc,pc_plus4,instr}_o; fetch_fault_o; fetch_count_o.
module instruction_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;
  logic         load;
  logic         bubble;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    count_d = count_q;
    load    = 1'b0;
    bubble  = 1'b0;

    unique case (state_q)
      BOOT: begin
        // First cycle out of reset: present RESET_PC, leave IF/ID untouched.
        state_d = RUN;
      end

      RUN: begin
        if (redirect_valid_i) begin
          bubble = 1'b1;  // fall-through instruction is wrong-path
          if (!is_word_aligned(redirect_pc_i)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc_i;
          end
        end else if (stall_i) begin
          bubble = flush_i;  // stall keeps the PC; flush still kills IF/ID
        end else if (flush_i) begin
          pc_d   = pc_next(pc_q);
          bubble = 1'b1;
        end else begin
          pc_d    = pc_next(pc_q);
          load    = 1'b1;
          count_d = count_q + 32'd1;
        end
      end

      FAULT: begin
        // Frozen until reset; keep IF/ID empty.
        bubble = 1'b1;
      end

      default: begin
        state_d = FAULT;
        fault_d = 1'b1;
        bubble  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .bubble_i   (bubble),
    .pc_i       (pc_q),
    .instr_i    (imem_instr),
    .valid_o    (if_id_valid_o),
    .pc_o       (if_id_pc_o),
    .pc_plus4_o (if_id_pc_plus4_o),
    .instr_o    (if_id_instr_o)
  );

  // Straight from the flop: no logic between pc_q and the memory address.
  assign imem_addr     = pc_q;
  assign fetch_fault_o = fault_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed plan items plus randomized
// stall/flush/redirect traffic against a transaction-level reference model.
// Second instance exercises a reset vector near the top of the address space.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default reset vector
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        stall_i, flush_i, redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid_o, fetch_fault_o;
  logic [31:0] if_id_pc_o, if_id_pc_plus4_o, if_id_instr_o, fetch_count_o;

  // DUT 1: reset vector 0xFFFF_FFF8
  logic        rst_n1;
  logic [31:0] imem_addr1, imem_instr1;
  logic        idle1 = 1'b0;
  logic [31:0] zero1 = 32'h0;
  logic        if_id_valid1, fetch_fault1;
  logic [31:0] if_id_pc1, if_id_pc_plus41, if_id_instr1, fetch_count1;

  int n_chk  = 0;
  int n_pass = 0;

  // Standard 10-instruction image; other addresses return an address-derived pattern.
  function automatic logic [31:0] img(input logic [31:0] a);
    if (a[31:6] == 26'h0) begin
      case (a[5:2])
        4'd0: return 32'h0050_0113;
        4'd1: return 32'h0070_0193;
        4'd2: return 32'h0631_0463;
        4'd3: return 32'h0020_8233;
        4'd4: return 32'h0031_2023;
        4'd5: return 32'h0040_a283;
        4'd6: return 32'h0053_02b3;
        4'd7: return 32'h0062_f333;
        4'd8: return 32'h00a1_2223;
        4'd9: return 32'h4031_43b3;
        default: ;
      endcase
    end
    return {a[17:2], 16'h0033};
  endfunction

  assign imem_instr  = img(imem_addr);
  assign imem_instr1 = img(imem_addr1);

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall_i(stall_i), .flush_i(flush_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o),
    .if_id_pc_plus4_o(if_id_pc_plus4_o), .if_id_instr_o(if_id_instr_o),
    .fetch_fault_o(fetch_fault_o), .fetch_count_o(fetch_count_o)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst_n(rst_n1),
    .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .stall_i(idle1), .flush_i(idle1),
    .redirect_valid_i(idle1), .redirect_pc_i(zero1),
    .if_id_valid_o(if_id_valid1), .if_id_pc_o(if_id_pc1),
    .if_id_pc_plus4_o(if_id_pc_plus41), .if_id_instr_o(if_id_instr1),
    .fetch_fault_o(fetch_fault1), .fetch_count_o(fetch_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: what the pipeline should look like after each edge.
  logic        m_booting, m_faulted, m_valid;
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;

  task automatic model_reset();
    m_booting = 1'b1; m_faulted = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_count = 32'h0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  imem_addr,        m_pc);
    check({tag, ".valid"}, {31'h0, if_id_valid_o}, {31'h0, m_valid});
    check({tag, ".pc"},    if_id_pc_o,       m_ifpc);
    check({tag, ".pc4"},   if_id_pc_plus4_o, m_ifpc + 32'd4);
    check({tag, ".instr"}, if_id_instr_o,    m_instr);
    check({tag, ".fault"}, {31'h0, fetch_fault_o}, {31'h0, m_faulted});
    check({tag, ".count"}, fetch_count_o,    m_count);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all({tag, ".rst"});
    rst_n = 1'b1;
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, compare.
  task automatic step(input string tag, input logic s, input logic f,
                      input logic rv, input logic [31:0] rpc);
    logic [31:0] fetched;
    stall_i = s; flush_i = f; redirect_valid_i = rv; redirect_pc_i = rpc;
    fetched = img(m_pc);
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_faulted) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (rv && rpc[1:0] != 2'b00) begin
      m_faulted = 1'b1; m_valid = 1'b0; m_instr = NOP;
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_instr = NOP;
    end else if (s) begin
      if (f) begin m_valid = 1'b0; m_instr = NOP; end
    end else if (f) begin
      m_pc = m_pc + 32'd4; m_valid = 1'b0; m_instr = NOP;
    end else begin
      m_ifpc = m_pc; m_instr = fetched; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; rst_n1 = 1'b0;

    // Straight-line fetch of the image
    do_reset("run");
    step("boot", 0, 0, 0, 32'h0);
    check("boot.valid0", {31'h0, if_id_valid_o}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("run%0d", i), 0, 0, 0, 32'h0);
      if (i == 0) check("run.first_instr", if_id_instr_o, 32'h0050_0113);
    end
    check("run.last_instr", if_id_instr_o, 32'h4031_43b3);
    check("run.count10", fetch_count_o, 32'd10);

    // Stall at pc 0x0C
    do_reset("stl");
    for (int i = 0; i < 4; i++) step($sformatf("stl_pre%0d", i), 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), 1, 0, 0, 32'h0);
    check("stall.addr", imem_addr, 32'h0C);
    check("stall.instr", if_id_instr_o, 32'h0631_0463);
    step("resume", 0, 0, 0, 32'h0);
    check("resume.pc", if_id_pc_o, 32'h0C);

    // Redirect 0x10 -> 0x20
    step("redir", 0, 0, 1, 32'h20);
    check("redir.addr", imem_addr, 32'h20);
    step("redir_tgt", 0, 0, 0, 32'h0);
    check("redir_tgt.instr", if_id_instr_o, 32'h00a1_2223);
    check("redir_tgt.pc4", if_id_pc_plus4_o, 32'h24);

    // Redirect beats stall and flush
    step("rsf", 1, 1, 1, 32'h08);
    check("rsf.addr", imem_addr, 32'h08);
    step("flush_stall", 1, 1, 0, 32'h0);
    step("flush_only", 0, 1, 0, 32'h0);

    // Randomized traffic, aligned redirects only
    for (int i = 0; i < 400; i++) begin
      logic s, f, rv;
      logic [31:0] t;
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 6) == 0);
      rv = ($urandom_range(0, 9) == 0);
      t  = {24'h0, $urandom_range(0, 63) == 0 ? 6'd0 : 6'($urandom_range(0, 63)), 2'b00};
      step($sformatf("rnd%0d", i), s, f, rv, t);
    end

    // Misaligned redirect traps
    step("mis", 0, 0, 1, 32'h22);
    check("mis.fault", {31'h0, fetch_fault_o}, 32'h1);
    for (int i = 0; i < 6; i++)
      step($sformatf("fault%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), {24'h0, 8'($urandom_range(0, 255)) & 8'hFC});
    do_reset("clr");
    check("clr.fault", {31'h0, fetch_fault_o}, 32'h0);

    // Wrap-around reset vector on the second instance
    #2;
    rst_n1 = 1'b1;
    @(posedge clk); #1;
    check("wrap.boot_addr", imem_addr1, 32'hFFFF_FFF8);
    check("wrap.boot_valid", {31'h0, if_id_valid1}, 32'h0);
    @(posedge clk); #1;
    check("wrap.addr1", imem_addr1, 32'hFFFF_FFFC);
    check("wrap.ifpc1", if_id_pc1, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap.addr2", imem_addr1, 32'h0000_0000);
    check("wrap.ifpc2", if_id_pc1, 32'hFFFF_FFFC);
    check("wrap.pc4", if_id_pc_plus41, 32'h0000_0000);
    check("wrap.fault", {31'h0, fetch_fault1}, 32'h0);
    check("wrap.count", fetch_count1, 32'd2);
    @(posedge clk); #2;
    rst_n1 = 1'b0;
    #1;
    check("arst.addr", imem_addr1, 32'hFFFF_FFF8);
    check("arst.valid", {31'h0, if_id_valid1}, 32'h0);
    check("arst.instr", if_id_instr1, NOP);
    check("arst.pc", if_id_pc1, 32'h0);
    check("arst.pc4", if_id_pc_plus41, 32'h4);
    check("arst.count", fetch_count1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
